// File: rtl/seven_seg_mux.sv
// Time-multiplexed N-digit common-anode seven-segment driver with tear-free shadow loading and PWM brightness.
// Define SEVEN_SEG_LZB_EN to enable leading-zero blanking of the displayed value.
module seven_seg_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 12500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic [3:0]              bright,
    output logic                    busy,
    output logic                    frame_tick,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int CW   = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int NIB  = 4;
    localparam int STEP = DIGIT_CYCLES / 16;
    localparam logic [CW-1:0]         CNT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

    // Segment pattern for a hex nibble, bit0 = A .. bit6 = G, 1 = lit.
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b0111111;
            4'h1:    pat = 7'b0000110;
            4'h2:    pat = 7'b1011011;
            4'h3:    pat = 7'b1001111;
            4'h4:    pat = 7'b1100110;
            4'h5:    pat = 7'b1101101;
            4'h6:    pat = 7'b1111101;
            4'h7:    pat = 7'b0000111;
            4'h8:    pat = 7'b1111111;
            4'h9:    pat = 7'b1101111;
            4'hA:    pat = 7'b1110111;
            4'hB:    pat = 7'b1111100;
            4'hC:    pat = 7'b0111001;
            4'hD:    pat = 7'b1011110;
            4'hE:    pat = 7'b1111001;
            4'hF:    pat = 7'b1110001;
            default: pat = 7'b0000000;
        endcase
        return pat;
    endfunction

    logic [CW-1:0]           cnt_r;
    logic [IW-1:0]           idx_r;
    logic [4*NUM_DIGITS-1:0] act_data_r, pend_data_r;
    logic [NUM_DIGITS-1:0]   act_dp_r, pend_dp_r, act_blank_r, pend_blank_r;
    logic [NUM_DIGITS-1:0]   lzb_s;
    logic [3:0]              bright_r;
    logic                    busy_r, frame_tick_r;
    logic [NUM_DIGITS-1:0]   an_r, an_s;
    logic [6:0]              seg_r, seg_s;
    logic                    dp_r, dp_s;
    logic                    wrap_s, frame_end_s, on_s, dark_s;
    logic [3:0]              nib_s;
    logic [31:0]             thr_s;

    assign wrap_s      = (cnt_r == CNT_LAST);
    assign frame_end_s = wrap_s && (idx_r == IDX_LAST);

    // Slot counter, digit index, frame pulse and once-per-slot brightness sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r        <= {CW{1'b0}};
            idx_r        <= {IW{1'b0}};
            frame_tick_r <= 1'b0;
            bright_r     <= 4'd15;
        end else begin
            frame_tick_r <= frame_end_s;
            if (cnt_r == {CW{1'b0}}) begin
                bright_r <= bright;
            end
            if (wrap_s) begin
                cnt_r <= {CW{1'b0}};
                idx_r <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1);
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // Shadow registers: loads wait in pending until the frame boundary, except a load on the boundary itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_data_r   <= {(4*NUM_DIGITS){1'b0}};
            act_dp_r     <= {NUM_DIGITS{1'b0}};
            act_blank_r  <= {NUM_DIGITS{1'b0}};
            pend_data_r  <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_r    <= {NUM_DIGITS{1'b0}};
            pend_blank_r <= {NUM_DIGITS{1'b0}};
            busy_r       <= 1'b0;
        end else if (load && frame_end_s) begin
            act_data_r  <= data_in;
            act_dp_r    <= dp_in;
            act_blank_r <= blank_in;
            busy_r      <= 1'b0;
        end else if (frame_end_s) begin
            if (busy_r) begin
                act_data_r  <= pend_data_r;
                act_dp_r    <= pend_dp_r;
                act_blank_r <= pend_blank_r;
            end
            busy_r <= 1'b0;
        end else if (load) begin
            pend_data_r  <= data_in;
            pend_dp_r    <= dp_in;
            pend_blank_r <= blank_in;
            busy_r       <= 1'b1;
        end
    end

`ifdef SEVEN_SEG_LZB_EN
    logic zero_run_s;

    // Walk down from the top digit; a digit is suppressed while everything above and including it is zero with no dp.
    always_comb begin
        zero_run_s = 1'b1;
        lzb_s      = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_s = zero_run_s && (act_data_r[i*NIB +: NIB] == 4'd0) && !act_dp_r[i];
            if (i > 0) begin
                lzb_s[i] = zero_run_s;
            end else begin
                lzb_s[i] = 1'b0;
            end
        end
    end
`else
    assign lzb_s = {NUM_DIGITS{1'b0}};
`endif

    // Next output values; cnt 0 of every slot is forced dark so adjacent digits never overlap.
    always_comb begin
        an_s   = {NUM_DIGITS{1'b1}};
        seg_s  = 7'h7F;
        dp_s   = 1'b1;
        nib_s  = act_data_r[{idx_r, 2'b00} +: NIB];
        thr_s  = (32'(bright_r) + 32'd1) * 32'(STEP);
        on_s   = (cnt_r != {CW{1'b0}}) && ((bright_r == 4'd15) || (32'(cnt_r) < thr_s));
        dark_s = act_blank_r[idx_r] || lzb_s[idx_r];
        if (on_s && !dark_s) begin
            an_s  = ~(AN_ONE << idx_r);
            seg_s = ~decode_hex(nib_s);
            dp_s  = ~act_dp_r[idx_r];
        end else begin
            an_s  = {NUM_DIGITS{1'b1}};
            seg_s = 7'h7F;
            dp_s  = 1'b1;
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_r  <= {NUM_DIGITS{1'b1}};
            seg_r <= 7'h7F;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_s;
            seg_r <= seg_s;
            dp_r  <= dp_s;
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign dp         = dp_r;
    assign busy       = busy_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Self-checking bench for seven_seg_mux (4 digits, 32-clock slots); vectors table plus hand-written corner sequences.
module tb_seven_seg_mux;

    localparam int ND = 4;
    localparam int DC = 32;
    // Active-low segment codes for 0..F as they must appear on the pins.
    localparam logic [6:0] SEG_LUT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dpv;
        logic [3:0]  blank;
        logic [3:0]  bright;
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0, blank_in = 4'h0, bright = 4'd15;
    logic        load = 1'b0;
    logic        busy, frame_tick, dp;
    logic [3:0]  an;
    logic [6:0]  seg;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    vec_t vecs[8];
    int   scan_low[4], scan_dpl[4];
    int   scan_multi, scan_gap_bad, scan_tick;

    seven_seg_mux #(.NUM_DIGITS(ND), .DIGIT_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
        .load(load), .bright(bright), .busy(busy), .frame_tick(frame_tick),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the first negedge where frame_tick is high, bounded.
    task automatic sync_frame();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_tick !== 1'b1 && k < 300);
        check("frame_sync", {31'd0, frame_tick}, 32'd1);
    endtask

    // Expected pins at mid-slot (cnt 15) of digit d for a vector.
    function automatic exp_t model(input vec_t v, input int d);
        exp_t e;
        logic lz, lit;
        lz = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
        if (d > 0) begin
            lz = 1'b1;
            for (int j = d; j < ND; j++) begin
                if (v.data[4*j +: 4] != 4'd0 || v.dpv[j]) lz = 1'b0;
            end
        end
`endif
        lit = !v.blank[d] && !lz && ((v.bright == 4'd15) || (15 < (int'(v.bright) + 1) * (DC / 16)));
        if (lit) begin
            e.an  = ~(4'b0001 << d);
            e.seg = SEG_LUT[v.data[4*d +: 4]];
            e.dp  = ~v.dpv[d];
        end else begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end
        return e;
    endfunction

    // Pop one expectation per digit and compare at mid-slot; m0 is the current position within the frame.
    task automatic check_digits(input int m0);
        int   m = m0;
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            step(32*d + 16 - m);
            m = 32*d + 16;
            e = exp_q.pop_front();
            check($sformatf("an_d%0d", d), {28'd0, an}, {28'd0, e.an});
            check($sformatf("seg_d%0d", d), {25'd0, seg}, {25'd0, e.seg});
            check($sformatf("dp_d%0d", d), {31'd0, dp}, {31'd0, e.dp});
        end
    endtask

    task automatic push_exp(input vec_t v);
        for (int d = 0; d < ND; d++) exp_q.push_back(model(v, d));
    endtask

    task automatic drive_vec(input vec_t v);
        data_in  = v.data;
        dp_in    = v.dpv;
        blank_in = v.blank;
        bright   = v.bright;
    endtask

    task automatic apply_vec(input vec_t v);
        sync_frame();
        step(2);
        drive_vec(v);
        load = 1'b1;
        step(1);
        load = 1'b0;
        check("busy_set", {31'd0, busy}, 32'd1);
        push_exp(v);
        step(50);
        check("busy_hold", {31'd0, busy}, 32'd1);
        sync_frame();
        check("busy_clr", {31'd0, busy}, 32'd0);
        check_digits(0);
    endtask

    // Observe one full frame starting just after a frame_tick negedge.
    task automatic scan_frame();
        int s;
        for (int i = 0; i < 4; i++) begin
            scan_low[i] = 0;
            scan_dpl[i] = 0;
        end
        scan_multi = 0; scan_gap_bad = 0; scan_tick = -1;
        for (int m = 1; m <= 128; m++) begin
            @(negedge clk);
            s = (m - 1) / 32;
            if (an != 4'hF) scan_low[s]++;
            if (dp == 1'b0) scan_dpl[s]++;
            if ($countones(~an) > 1) scan_multi++;
            if ((m % 32) == 1 && an != 4'hF) scan_gap_bad++;
            if (frame_tick && scan_tick < 0) scan_tick = m;
        end
    endtask

    initial begin
        vec_t v;
        int   low0, low1;
        vecs[0] = '{16'h0000, 4'b0000, 4'b0000, 4'd15};
        vecs[1] = '{16'h1A3F, 4'b0000, 4'b0000, 4'd15};
        vecs[2] = '{16'h4567, 4'b0011, 4'b0000, 4'd7};
        vecs[3] = '{16'h89BC, 4'b1010, 4'b0100, 4'd15};
        vecs[4] = '{16'h0042, 4'b0000, 4'b0000, 4'd15};
        vecs[5] = '{16'h0005, 4'b1000, 4'b0000, 4'd15};
        vecs[6] = '{16'h7777, 4'b0000, 4'b0000, 4'd6};
        vecs[7] = '{16'h0300, 4'b0000, 4'b0000, 4'd15};

        step(3);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tick", {31'd0, frame_tick}, 32'd0);
        rst = 1'b1;

        // Free-running scan after reset.
        sync_frame();
        scan_frame();
        for (int i = 0; i < 4; i++) check($sformatf("full_low_s%0d", i), scan_low[i], 32'd31);
        check("onehot", scan_multi, 32'd0);
        check("wrap_gap", scan_gap_bad, 32'd0);
        check("tick_period", scan_tick, 32'd128);

        for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

        // dp on digit 2, digit 0 blanked.
        v = '{16'hDE20, 4'b0100, 4'b0001, 4'd15};
        apply_vec(v);
        sync_frame();
        scan_frame();
        check("blank_d0_low", scan_low[0], 32'd0);
        check("dp_s2", scan_dpl[2], 32'd31);
        check("dp_others", scan_dpl[0] + scan_dpl[1] + scan_dpl[3], 32'd0);

        // Two loads within a frame: last wins.
        sync_frame();
        step(2);
        drive_vec('{16'h1111, 4'b0000, 4'b0000, 4'd15});
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(5);
        v = '{16'h2222, 4'b0000, 4'b0000, 4'd15};
        drive_vec(v);
        load = 1'b1;
        step(1);
        load = 1'b0;
        check("busy_2load", {31'd0, busy}, 32'd1);
        push_exp(v);
        sync_frame();
        check("busy_2clr", {31'd0, busy}, 32'd0);
        check_digits(0);

        // Load exactly on the boundary cycle bypasses pending.
        sync_frame();
        step(127);
        v = '{16'h5A5A, 4'b0000, 4'b0000, 4'd15};
        drive_vec(v);
        load = 1'b1;
        check("busy_pre_bnd", {31'd0, busy}, 32'd0);
        step(1);
        load = 1'b0;
        check("tick_bnd", {31'd0, frame_tick}, 32'd1);
        check("busy_bnd", {31'd0, busy}, 32'd0);
        step(1);
        check("busy_bnd_next", {31'd0, busy}, 32'd0);
        push_exp(v);
        check_digits(1);

        // PWM: bright 3 gives 7 lit clocks per slot; a mid-slot change waits for the next slot.
        bright = 4'd3;
        sync_frame();
        scan_frame();
        for (int i = 0; i < 4; i++) check($sformatf("pwm3_s%0d", i), scan_low[i], 32'd7);
        low0 = 0;
        low1 = 0;
        for (int m = 1; m <= 64; m++) begin
            @(negedge clk);
            if (an != 4'hF) begin
                if (m <= 32) low0++;
                else low1++;
            end
            if (m == 10) bright = 4'd15;
        end
        check("pwm_mid_old", low0, 32'd7);
        check("pwm_mid_new", low1, 32'd31);

        // Asynchronous reset mid-slot, then restart at digit 0.
        step(8);
        rst = 1'b0;
        #1;
        check("arst_an", {28'd0, an}, 32'hF);
        check("arst_seg", {25'd0, seg}, 32'h7F);
        check("arst_dp", {31'd0, dp}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_tick", {31'd0, frame_tick}, 32'd0);
        step(2);
        rst = 1'b1;
        step(1);
        check("restart_gap", {28'd0, an}, 32'hF);
        step(1);
        check("restart_an", {28'd0, an}, 32'hE);
        check("restart_seg", {25'd0, seg}, 32'h40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_mux.md
Name: seven_seg_mux

Overview:
Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display. Drives active-low anodes and cathodes from the board clock. Successor to the fixed 4-digit driver, adding:
- configurable digit count and slot length
- tear-free shadow loading with a handshake
- per-digit decimal points and blanking
- 16-level PWM brightness

Sits between register-file/debug logic and the board's seven-segment pins.

Parameters:
NUM_DIGITS, 4, number of digits (1..8)
DIGIT_CYCLES, 12500, clocks per digit slot (>=16); 0.25 ms at 50 MHz

Ports:
clk  in  1  system clock (50 MHz on board)
rst  in  1  asynchronous active-low reset
data_in  in  4*NUM_DIGITS  hex nibbles; nibble i shows on digit i
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
blank_in  in  NUM_DIGITS  1 = digit i dark
load  in  1  1-cycle strobe; captures data_in/dp_in/blank_in
bright  in  4  brightness 0 (dimmest) .. 15 (full)
busy  out  1  1 while a captured load awaits the frame boundary
frame_tick  out  1  1-cycle pulse at the end of each full scan
an  out  NUM_DIGITS  anodes, active-low
seg  out  7  cathodes A..G = seg[0]..seg[6], active-low
dp  out  1  decimal point cathode, active-low

Behaviour:
- Reset (rst=0, async) sets: an all 1, seg 7'h7F, dp 1, busy 0, frame_tick 0, slot counter cnt 0, digit index idx 0, active/pending data 0, bright_r 15.
- cnt counts 0..DIGIT_CYCLES-1 and wraps.
- On wrap, idx advances 0..NUM_DIGITS-1 and wraps to 0.
- Frame boundary is the cycle where cnt==DIGIT_CYCLES-1 and idx==NUM_DIGITS-1. frame_tick pulses on the following cycle.
- Shadow load:
  - load=1 copies inputs to pending registers and sets busy next cycle.
  - At the frame boundary, pending copies to active and busy clears.
  - Repeated loads before the boundary: last one wins.
  - load on the boundary cycle bypasses pending: inputs go straight to active, busy stays 0.
- bright is sampled into bright_r when cnt==0 only. Mid-slot changes take effect next slot.
- PWM: STEP = DIGIT_CYCLES/16 (integer division).
  - Digit idx is "on" when cnt < (bright_r+1)*STEP.
  - bright_r==15 is on for the whole slot.
- Output register (1-cycle latency from cnt/idx):
  - If on and active blank[idx]==0: an = ~(1<<idx), seg = ~decode(nibble idx), dp = ~active_dp[idx].
  - Otherwise: an all 1, seg 7'h7F, dp 1.
- Decode (1 = segment lit, listed bit6..bit0 as G..A):
  - 0:0111111, 1:0000110, 2:1011011, 3:1001111, 4:1100110, 5:1101101, 6:1111101, 7:0000111
  - 8:1111111, 9:1101111, A:1110111, b:1111100, C:0111001, d:1011110, E:1111001, F:1110001
- At most one an bit is low in any cycle.
- On the cycle cnt wraps, an is all 1 for that one cycle (anti-ghosting gap).
- NUM_DIGITS=1: idx is constant 0, and every slot wrap is a frame boundary.
- Counter widths are $clog2 of their range, minimum 1 bit. No overflow beyond the stated wrap points.

Optional Feature:
SEVEN_SEG_LZB_EN
- Defined: leading-zero blanking on the active data.
  - Digit i>0 is forced dark when every nibble j>=i is 0 and no dp j>=i is set.
  - Digit 0 is never suppressed.
  - Applied after blank_in (OR-ed).
- Undefined: all non-blanked digits display, including leading zeros.

Test Plan:
All scenarios use NUM_DIGITS=4, DIGIT_CYCLES=32.
1. Reset release, no load -> an cycles 1110,1101,1011,0111 every 32 clks (with 1-clk all-1 gap at each wrap), seg=7'h40 ("0") in every slot, frame_tick every 128 clks.
2. load data_in=16'h1A3F, bright=15 -> busy=1 until the next frame boundary; next frame digit0 seg=7'h0E (F), digit1 7'h30 (3), digit2 7'h08 (A), digit3 7'h79 (1).
3. Two loads (16'h1111 then 16'h2222) within one frame -> only 2222 displayed; load exactly on the boundary cycle -> displayed in the next frame, busy never asserted.
4. bright=3 -> an low for 7 clks of each 32-clk slot (cnt 1..7 at 1-cycle latency). bright changed mid-slot -> new duty starts next slot.
5. dp_in=4'b0100, blank_in=4'b0001 -> digit0 anode never low, dp=0 only in digit2's slot. Assert rst low mid-slot -> outputs at reset values immediately, scan restarts at digit0.
6. SEVEN_SEG_LZB_EN defined, data 16'h0042 -> digits 2,3 dark, digits 0,1 lit. Data 16'h0000 -> only digit0 lit with "0".
